seq_contador_ctrl: RTL and testbench
====================================

SEQ_CONTADOR_CTRL -- requirements
Module: seq_contador_ctrl

Interface
REQ-001 The block SHALL take parameter N_ENT, default 8, giving the number of sequence-table entries (power of two).
REQ-002 The block SHALL take parameter W, default 4, giving the output value width.
REQ-003 Port C SHALL be an input, 1 bit wide, and the single clock; all state changes occur on its rising edge.
REQ-004 Port RN SHALL be an input, 1 bit wide, and the reset: asynchronous, active-low.
REQ-005 Port WE SHALL be an input, 1 bit wide: table write enable.
REQ-006 Port WA SHALL be an input, log2(N_ENT) bits wide: table write address.
REQ-007 Port WD SHALL be an input, W bits wide: table write data.
REQ-008 Port LEN SHALL be an input, log2(N_ENT) bits wide: index of the last sequence entry.
REQ-009 Port MODE SHALL be an input, 1 bit wide: 0 = cyclic, 1 = one-shot.
REQ-010 Port START SHALL be an input, 1 bit wide: start from IDLE, or resume from PAUSE.
REQ-011 Port STOP SHALL be an input, 1 bit wide: pause from RUN, or abort from PAUSE.
REQ-012 Port STEP SHALL be an input, 1 bit wide: single advance while in PAUSE.
REQ-013 Port Q SHALL be an output, W bits wide: current sequence value, registered.
REQ-014 Port IDX SHALL be an output, log2(N_ENT) bits wide: current table index, registered.
REQ-015 Port BUSY SHALL be an output, 1 bit wide, high in RUN or PAUSE.
REQ-016 Port DONE SHALL be an output, 1 bit wide: one-cycle pulse on one-shot completion.
REQ-017 Port WERR SHALL be an output, 1 bit wide: one-cycle pulse on a rejected write.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-019 In IDLE with START=1 and STOP=0, the block SHALL latch LEN and MODE, set IDX=0 and Q=table[0] on the same edge, and enter RUN.
REQ-020 In RUN, each cycle without STOP SHALL advance to the next entry:
  - if IDX<LEN_latched: IDX+1, with Q=table[IDX+1] on the same edge;
  - if IDX==LEN_latched and cyclic: wrap to IDX=0, Q=table[0];
  - if IDX==LEN_latched and one-shot: enter IDLE, hold IDX and Q, pulse DONE for one cycle.
REQ-021 In RUN with STOP=1, the block SHALL enter PAUSE without advancing; STOP takes priority over advance and over START.
REQ-022 In PAUSE, the block SHALL respond as follows:
  - STOP=1: abort to IDLE, holding Q/IDX, with no DONE;
  - else START=1: return to RUN, with no advance that cycle;
  - else STEP=1: advance once per REQ-020 rules and stay in PAUSE, except a one-shot end, which goes to IDLE with a DONE pulse.
REQ-023 In PAUSE, START and STEP asserted together SHALL act as START only.
REQ-024 The block SHALL ignore STEP outside PAUSE, START in RUN, and STOP in IDLE.
REQ-025 Table writes (WE=1) SHALL be accepted only in IDLE, writing WD to table[WA] on the edge.
REQ-026 A WE=1 outside IDLE SHALL leave the table unchanged and pulse WERR on the next cycle.
REQ-027 A write in IDLE SHALL NOT change Q; Q reflects the table only when an advance or start occurs.
REQ-028 LEN and MODE changes while BUSY SHALL have no effect until the next start from IDLE.
REQ-029 When LEN=0, a cyclic sequence SHALL hold table[0] on every cycle, and a one-shot sequence SHALL complete on the first RUN cycle.
REQ-030 The block SHALL have no combinational path from any input to any output.

Reset
REQ-031 While RN=0, the block SHALL force the state to IDLE, with Q=0, IDX=0, BUSY=0, DONE=0, WERR=0, LEN_latched=0 and MODE_latched=0.
REQ-032 Reset SHALL load table[i]=i mod 2^W, so the default sequence is an up-count.
REQ-033 Reset asserted mid-RUN SHALL abort immediately without a DONE pulse.
REQ-034 After RN deasserts, the block SHALL require an explicit START before running.

Structure
REQ-035 A shared package seq_pkg SHALL hold the state enumeration (IDLE/RUN/PAUSE), the N_ENT and W defaults, and the derived index width.
REQ-036 The table SHALL be a separate sub-module seq_tabla: N_ENT x W registers with synchronous write, asynchronous read, and reset-to-index initialisation.

Verification
REQ-037 Scenario: after reset, START, LEN=7, MODE=0 -> Q runs 0,1,...,7,0,1 on consecutive edges, BUSY=1, DONE stays 0.
REQ-038 Scenario: write the table with 3,5,9,12 at addresses 0..3, then LEN=3, MODE=1, START -> Q=3,5,9,12, then IDLE with Q=12 held, DONE high exactly one cycle, BUSY=0.
REQ-039 Scenario: STOP in RUN at Q=5 -> Q holds 5; STEP twice -> Q=9 then 12; START -> running resumes from 12.
REQ-040 Scenario: START and STOP in the same cycle while in RUN -> PAUSE entered; START and STOP in the same cycle while in PAUSE -> IDLE, no DONE.
REQ-041 Scenario: WE=1 with WA=2, WD=15 while BUSY -> WERR pulses one cycle and table[2] is unchanged on the next pass.
REQ-042 Scenario: RN pulsed low mid-RUN at Q=9 -> Q=0, IDX=0 immediately, table restored to identity, DONE=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence counter controller: state encoding,
// default geometry and the derived table index width.
package seq_pkg;

  localparam int unsigned N_ENT_DEF = 8;
  localparam int unsigned W_DEF     = 4;
  localparam int unsigned IW_DEF    = $clog2(N_ENT_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_tabla.sv
// Sequence table: N_ENT x W registers, synchronous write, asynchronous read.
// Reset loads each entry with its own index so the default sequence counts up.
module seq_tabla #(
  parameter int unsigned N_ENT = 8,
  parameter int unsigned W     = 4,
  parameter int unsigned IW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [IW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [N_ENT];

  // Table storage: identity load on reset, single-entry write otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ENT; i++) begin
        mem[i] <= W'(i);
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/seq_contador_ctrl.sv
// Table-driven sequence counter with IDLE/RUN/PAUSE control, single-step,
// cyclic or one-shot operation, and write protection while busy.
module seq_contador_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned N_ENT = N_ENT_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                     C,
  input  logic                     RN,
  input  logic                     WE,
  input  logic [$clog2(N_ENT)-1:0] WA,
  input  logic [W-1:0]             WD,
  input  logic [$clog2(N_ENT)-1:0] LEN,
  input  logic                     MODE,
  input  logic                     START,
  input  logic                     STOP,
  input  logic                     STEP,
  output logic [W-1:0]             Q,
  output logic [$clog2(N_ENT)-1:0] IDX,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     WERR
);

  localparam int unsigned IW = $clog2(N_ENT);

  seq_state_t    state_q, state_d;
  logic [IW-1:0] len_q, len_d;
  logic          mode_q, mode_d;
  logic [IW-1:0] idx_d;
  logic [W-1:0]  q_d;
  logic          done_d, werr_d;
  logic          advance;

  logic          last;
  logic [IW-1:0] nxt_idx;
  logic [IW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          tbl_we;

  // The single read port always looks at the entry the next move would land
  // on (0 when starting), so Q can load it on the same edge.
  assign last    = (IDX == len_q);
  assign nxt_idx = last ? '0 : IDX + IW'(1);
  assign rd_addr = (state_q == IDLE) ? '0 : nxt_idx;
  assign tbl_we  = WE && (state_q == IDLE);
  assign BUSY    = (state_q != IDLE);

  seq_tabla #(
    .N_ENT (N_ENT),
    .W     (W),
    .IW    (IW)
  ) u_tabla (
    .clk   (C),
    .rst_n (RN),
    .we    (tbl_we),
    .wa    (WA),
    .wd    (WD),
    .ra    (rd_addr),
    .rd    (rd_data)
  );

  // Next-state, next-output and latched-configuration logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    idx_d   = IDX;
    q_d     = Q;
    done_d  = 1'b0;
    werr_d  = WE && (state_q != IDLE);
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (START && !STOP) begin
          len_d   = LEN;
          mode_d  = MODE;
          idx_d   = '0;
          q_d     = rd_data;
          state_d = RUN;
        end
      end
      RUN: begin
        if (STOP) state_d = PAUSE;
        else      advance = 1'b1;
      end
      PAUSE: begin
        if (STOP)       state_d = IDLE;
        else if (START) state_d = RUN;
        else if (STEP)  advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Shared advance rule for RUN and PAUSE single-step; a one-shot end
    // holds Q/IDX and leaves to IDLE from either state.
    if (advance) begin
      if (last && mode_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d = nxt_idx;
        q_d   = rd_data;
      end
    end
  end

  // State, outputs and latched configuration registers
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      len_q   <= '0;
      mode_q  <= 1'b0;
      IDX     <= '0;
      Q       <= '0;
      DONE    <= 1'b0;
      WERR    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      IDX     <= idx_d;
      Q       <= q_d;
      DONE    <= done_d;
      WERR    <= werr_d;
    end
  end

endmodule

// File: tb/tb_seq_contador_ctrl.sv
// Directed bench for seq_contador_ctrl with a scoreboard of expected outputs.
module tb_seq_contador_ctrl;

  logic       C, RN, WE, MODE, START, STOP, STEP;
  logic [2:0] WA, LEN, IDX;
  logic [3:0] WD, Q;
  logic       BUSY, DONE, WERR;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic [2:0] idx;
    logic       busy;
    logic       done;
    logic       werr;
  } exp_t;

  exp_t sb[$];

  seq_contador_ctrl #(.N_ENT(8), .W(4)) dut (
    .C     (C),
    .RN    (RN),
    .WE    (WE),
    .WA    (WA),
    .WD    (WD),
    .LEN   (LEN),
    .MODE  (MODE),
    .START (START),
    .STOP  (STOP),
    .STEP  (STEP),
    .Q     (Q),
    .IDX   (IDX),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .WERR  (WERR)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input string fld,
                     input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s.%s got=%0h exp=%0h", tag, fld, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] q,
                            input logic [2:0] idx, input logic busy,
                            input logic done, input logic werr);
    exp_t e;
    e.tag = tag; e.q = q; e.idx = idx; e.busy = busy; e.done = done; e.werr = werr;
    sb.push_back(e);
  endtask

  task automatic check_pending();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, "Q",    {4'b0, Q},    {4'b0, e.q});
      chk(e.tag, "IDX",  {5'b0, IDX},  {5'b0, e.idx});
      chk(e.tag, "BUSY", {7'b0, BUSY}, {7'b0, e.busy});
      chk(e.tag, "DONE", {7'b0, DONE}, {7'b0, e.done});
      chk(e.tag, "WERR", {7'b0, WERR}, {7'b0, e.werr});
    end
  endtask

  // Register the expectation for the coming edge, then sample 1 time unit after it.
  task automatic tick(input string tag, input logic [3:0] q, input logic [2:0] idx,
                      input logic busy, input logic done, input logic werr);
    expect_out(tag, q, idx, busy, done, werr);
    @(posedge C);
    #1;
    check_pending();
  endtask

  initial begin
    RN = 1'b0; WE = 1'b0; WA = '0; WD = '0; LEN = '0; MODE = 1'b0;
    START = 1'b0; STOP = 1'b0; STEP = 1'b0;
    #2;
    expect_out("reset", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    check_pending();
    @(posedge C); #1;
    RN = 1'b1;
    tick("idle_after_reset", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Cyclic up-count over the identity table
    LEN = 3'd7; MODE = 1'b0; START = 1'b1;
    tick("cyc_start", 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick("cyc_run", 4'(i % 8), 3'(i % 8), 1'b1, 1'b0, 1'b0);
    end
    STOP = 1'b1;
    tick("cyc_pause", 4'd1, 3'd1, 1'b1, 1'b0, 1'b0);
    tick("cyc_abort", 4'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    STOP = 1'b0;

    // Table writes in IDLE leave Q alone
    WE = 1'b1;
    WA = 3'd0; WD = 4'd3;  tick("wr0", 4'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    WA = 3'd1; WD = 4'd5;  tick("wr1", 4'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    WA = 3'd2; WD = 4'd9;  tick("wr2", 4'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    WA = 3'd3; WD = 4'd12; tick("wr3", 4'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    WE = 1'b0;

    // One-shot run; LEN/MODE changes while busy must not matter
    LEN = 3'd3; MODE = 1'b1; START = 1'b1;
    tick("os_start", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0; LEN = 3'd7; MODE = 1'b0;
    tick("os_1", 4'd5, 3'd1, 1'b1, 1'b0, 1'b0);
    tick("os_2", 4'd9, 3'd2, 1'b1, 1'b0, 1'b0);
    tick("os_3", 4'd12, 3'd3, 1'b1, 1'b0, 1'b0);
    tick("os_done", 4'd12, 3'd3, 1'b0, 1'b1, 1'b0);
    tick("os_done_clr", 4'd12, 3'd3, 1'b0, 1'b0, 1'b0);

    // Pause, single-step, resume
    LEN = 3'd3; MODE = 1'b1; START = 1'b1;
    tick("ps_start", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    tick("ps_run", 4'd5, 3'd1, 1'b1, 1'b0, 1'b0);
    STOP = 1'b1;
    tick("ps_pause", 4'd5, 3'd1, 1'b1, 1'b0, 1'b0);
    STOP = 1'b0;
    tick("ps_hold", 4'd5, 3'd1, 1'b1, 1'b0, 1'b0);
    STEP = 1'b1;
    tick("ps_step1", 4'd9, 3'd2, 1'b1, 1'b0, 1'b0);
    tick("ps_step2", 4'd12, 3'd3, 1'b1, 1'b0, 1'b0);
    START = 1'b1;
    tick("ps_resume", 4'd12, 3'd3, 1'b1, 1'b0, 1'b0);
    START = 1'b0; STEP = 1'b0;
    tick("ps_done", 4'd12, 3'd3, 1'b0, 1'b1, 1'b0);
    tick("ps_done_clr", 4'd12, 3'd3, 1'b0, 1'b0, 1'b0);

    // One-shot end reached by STEP; STEP ignored in IDLE afterwards
    START = 1'b1;
    tick("st_start", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0; STOP = 1'b1;
    tick("st_pause", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    STOP = 1'b0; STEP = 1'b1;
    tick("st_s1", 4'd5, 3'd1, 1'b1, 1'b0, 1'b0);
    tick("st_s2", 4'd9, 3'd2, 1'b1, 1'b0, 1'b0);
    tick("st_s3", 4'd12, 3'd3, 1'b1, 1'b0, 1'b0);
    tick("st_done", 4'd12, 3'd3, 1'b0, 1'b1, 1'b0);
    tick("st_idle_step", 4'd12, 3'd3, 1'b0, 1'b0, 1'b0);
    STEP = 1'b0;

    // START+STOP together: RUN->PAUSE, PAUSE->IDLE without DONE
    MODE = 1'b0; START = 1'b1;
    tick("ss_start", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    STOP = 1'b1;
    tick("ss_pause", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    tick("ss_abort", 4'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    START = 1'b0; STOP = 1'b0;

    // Rejected write while busy
    START = 1'b1;
    tick("we_start", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0; WE = 1'b1; WA = 3'd2; WD = 4'd15;
    tick("we_busy", 4'd5, 3'd1, 1'b1, 1'b0, 1'b1);
    WE = 1'b0;
    tick("we_clr", 4'd9, 3'd2, 1'b1, 1'b0, 1'b0);
    tick("we_3", 4'd12, 3'd3, 1'b1, 1'b0, 1'b0);
    tick("we_wrap", 4'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    tick("we_p1", 4'd5, 3'd1, 1'b1, 1'b0, 1'b0);
    tick("we_tbl2", 4'd9, 3'd2, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-run
    RN = 1'b0;
    #1;
    expect_out("rst_mid", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    check_pending();
    @(posedge C); #1;
    RN = 1'b1;
    tick("rst_idle", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    LEN = 3'd3; MODE = 1'b0; START = 1'b1;
    tick("id_0", 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    tick("id_1", 4'd1, 3'd1, 1'b1, 1'b0, 1'b0);
    tick("id_2", 4'd2, 3'd2, 1'b1, 1'b0, 1'b0);
    tick("id_3", 4'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    STOP = 1'b1;
    tick("id_pause", 4'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    tick("id_abort", 4'd3, 3'd3, 1'b0, 1'b0, 1'b0);
    STOP = 1'b0;

    // LEN=0 boundary: cyclic holds entry 0, one-shot ends on first RUN cycle
    LEN = 3'd0; MODE = 1'b0; START = 1'b1;
    tick("l0c_start", 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    tick("l0c_a", 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick("l0c_b", 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    STOP = 1'b1;
    tick("l0c_pause", 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick("l0c_abort", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    STOP = 1'b0;
    MODE = 1'b1; START = 1'b1;
    tick("l0o_start", 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    tick("l0o_done", 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick("l0o_clr", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
